// File: rtl/alu_regfile_datapath.sv
// Execute-stage datapath slice: 32x32 register bank with two asynchronous read
// ports, an ALU fed by both ports, and a writeback mux in front of the write port.
module alu_regfile_datapath #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [AW-1:0]    sr1,
  input  logic [AW-1:0]    sr2,
  input  logic [AW-1:0]    dr,
  input  logic [WIDTH-1:0] wrData,
  input  logic             sel,
  input  logic             en,
  input  logic [3:0]       mode,
  output logic [WIDTH-1:0] rData1,
  output logic [WIDTH-1:0] rData2,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] wb_data,
  output logic             zero,
  output logic             sign,
  output logic             carry
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] aluRes;
  logic             carryOut;
  logic [4:0]       shamt;

  // Register 0 is an ordinary register; reset takes priority over a same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (write) begin
      regs[dr] <= wb_data;
    end
  end

  // No write-through bypass: a write becomes visible only after the edge.
  assign rData1 = regs[sr1];
  assign rData2 = regs[sr2];

  assign shamt = rData2[4:0];

  always_comb begin
    aluRes   = '0;
    carryOut = 1'b0;
    if (en) begin
      case (mode)
        4'd0:    {carryOut, aluRes} = {1'b0, rData1} + {1'b0, rData2};
        // The extra top bit of the difference is set exactly when A < B, i.e. a borrow.
        4'd1:    {carryOut, aluRes} = {1'b0, rData1} - {1'b0, rData2};
        4'd2:    aluRes = (~rData2) + WIDTH'(1);
        4'd3:    aluRes = rData1 & rData2;
        4'd4:    aluRes = rData1 | rData2;
        4'd5:    aluRes = rData1 ^ rData2;
        4'd6:    aluRes = rData1 << shamt;
        4'd7:    aluRes = rData1 >> shamt;
        4'd8:    aluRes = $signed(rData1) >>> shamt;
        4'd9:    aluRes = {{(WIDTH-1){1'b0}}, ($signed(rData1) < $signed(rData2))};
        4'd10:   aluRes = {{(WIDTH-1){1'b0}}, (rData1 < rData2)};
        default: aluRes = '0;
      endcase
    end
  end

  assign alu_out = aluRes;
  assign carry   = carryOut;
  assign zero    = (aluRes == '0);
  assign sign    = aluRes[WIDTH-1];
  assign wb_data = sel ? wrData : aluRes;

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Directed-vector bench for alu_regfile_datapath; stimulus pushes expectations
// into a queue and a negedge monitor pops and compares them.
module tb_alu_regfile_datapath;

  logic        clk = 1'b0;
  logic        reset, write, sel, en;
  logic [4:0]  sr1, sr2, dr;
  logic [31:0] wrData;
  logic [3:0]  mode;
  logic [31:0] rData1, rData2, alu_out, wb_data;
  logic        zero, sign, carry;

  int checks   = 0;
  int failures = 0;

  localparam int S_RD1 = 0, S_RD2 = 1, S_ALU = 2, S_WB = 3,
                 S_ZERO = 4, S_SIGN = 5, S_CARRY = 6;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] val;
  } expT;

  expT expQ[$];

  alu_regfile_datapath dut (
    .clk(clk), .reset(reset), .write(write), .sr1(sr1), .sr2(sr2), .dr(dr),
    .wrData(wrData), .sel(sel), .en(en), .mode(mode),
    .rData1(rData1), .rData2(rData2), .alu_out(alu_out), .wb_data(wb_data),
    .zero(zero), .sign(sign), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic wr, input logic sl, input logic e,
                               input logic [3:0] md, input logic [4:0] a,
                               input logic [4:0] b, input logic [4:0] d,
                               input logic [31:0] wd);
    write = wr; sel = sl; en = e; mode = md;
    sr1 = a; sr2 = b; dr = d; wrData = wd;
  endtask

  task automatic pushExp(input string name, input int sig, input logic [31:0] val);
    expT item;
    item.name = name; item.sig = sig; item.val = val;
    expQ.push_back(item);
  endtask

  // Advance past the next rising edge and let combinational outputs settle.
  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input expT item);
    logic [31:0] act;
    case (item.sig)
      S_RD1:   act = rData1;
      S_RD2:   act = rData2;
      S_ALU:   act = alu_out;
      S_WB:    act = wb_data;
      S_ZERO:  act = {31'b0, zero};
      S_SIGN:  act = {31'b0, sign};
      default: act = {31'b0, carry};
    endcase
    checks++;
    if (act !== item.val) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", item.name, act, item.val);
    end
  endtask

  always @(negedge clk) begin
    while (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b0;
    applyStimulus(0, 1, 0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    #1;
    // Dirty a register first so the reset check is meaningful.
    applyStimulus(1, 1, 0, 4'd0, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF);
    stepEdge();
    reset = 1'b1;
    applyStimulus(1, 1, 0, 4'd0, 5'd0, 5'd0, 5'd6, 32'hCAFEF00D);
    stepEdge();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 1, 0, 4'd0, 5'(i), 5'(31 - i), 5'd0, 32'h0);
      pushExp($sformatf("reset_rd1_r%0d", i), S_RD1, 32'h0);
      pushExp($sformatf("reset_rd2_r%0d", 31 - i), S_RD2, 32'h0);
      if (i == 0) begin
        pushExp("reset_alu_en0", S_ALU, 32'h0);
        pushExp("reset_zero_en0", S_ZERO, 32'h1);
      end
      stepEdge();
    end

    // Load r1=370, r2=4 through the external write-data path.
    applyStimulus(1, 1, 0, 4'd0, 5'd0, 5'd0, 5'd1, 32'd370);
    pushExp("load_wb_370", S_WB, 32'd370);
    stepEdge();
    applyStimulus(1, 1, 0, 4'd0, 5'd0, 5'd0, 5'd2, 32'd4);
    stepEdge();
    applyStimulus(0, 1, 0, 4'd0, 5'd1, 5'd2, 5'd1, 32'd999);
    pushExp("load_r1", S_RD1, 32'd370);
    pushExp("load_r2", S_RD2, 32'd4);
    stepEdge();
    pushExp("hold_r1", S_RD1, 32'd370);
    pushExp("hold_r2", S_RD2, 32'd4);
    stepEdge();

    // Add writeback into r3.
    applyStimulus(1, 0, 1, 4'd0, 5'd1, 5'd2, 5'd3, 32'h0);
    pushExp("add_alu", S_ALU, 32'd374);
    pushExp("add_wb", S_WB, 32'd374);
    pushExp("add_carry", S_CARRY, 32'h0);
    pushExp("add_zero", S_ZERO, 32'h0);
    stepEdge();
    applyStimulus(0, 0, 1, 4'd0, 5'd3, 5'd2, 5'd0, 32'h0);
    pushExp("add_r3", S_RD1, 32'd374);
    stepEdge();

    // Shifts: srl into r4, sll, then r5=0x80000000 for sra.
    applyStimulus(1, 0, 1, 4'd7, 5'd1, 5'd2, 5'd4, 32'h0);
    pushExp("srl_alu", S_ALU, 32'd23);
    stepEdge();
    applyStimulus(0, 0, 1, 4'd6, 5'd4, 5'd2, 5'd0, 32'h0);
    pushExp("srl_r4", S_RD1, 32'd23);
    pushExp("sll_23_4", S_ALU, 32'd368);
    stepEdge();
    applyStimulus(1, 1, 0, 4'd0, 5'd0, 5'd0, 5'd5, 32'h80000000);
    stepEdge();
    applyStimulus(1, 1, 1, 4'd8, 5'd5, 5'd2, 5'd7, 32'd1);
    pushExp("sra_alu", S_ALU, 32'hF8000000);
    pushExp("sra_sign", S_SIGN, 32'h1);
    stepEdge();
    applyStimulus(0, 0, 1, 4'd7, 5'd5, 5'd2, 5'd0, 32'h0);
    pushExp("srl_msb", S_ALU, 32'h08000000);
    stepEdge();

    // Subtract and flags; r7 now holds 1.
    applyStimulus(0, 0, 1, 4'd1, 5'd2, 5'd2, 5'd0, 32'h0);
    pushExp("sub_eq_alu", S_ALU, 32'h0);
    pushExp("sub_eq_zero", S_ZERO, 32'h1);
    pushExp("sub_eq_carry", S_CARRY, 32'h0);
    stepEdge();
    applyStimulus(0, 0, 1, 4'd1, 5'd0, 5'd7, 5'd0, 32'h0);
    pushExp("sub_borrow_alu", S_ALU, 32'hFFFFFFFF);
    pushExp("sub_borrow_sign", S_SIGN, 32'h1);
    pushExp("sub_borrow_carry", S_CARRY, 32'h1);
    stepEdge();
    applyStimulus(0, 0, 0, 4'd1, 5'd0, 5'd7, 5'd0, 32'h0);
    pushExp("en0_alu", S_ALU, 32'h0);
    pushExp("en0_carry", S_CARRY, 32'h0);
    pushExp("en0_zero", S_ZERO, 32'h1);
    stepEdge();
    applyStimulus(0, 0, 1, 4'd0, 5'd5, 5'd5, 5'd0, 32'h0);
    pushExp("add_wrap_alu", S_ALU, 32'h0);
    pushExp("add_wrap_carry", S_CARRY, 32'h1);
    stepEdge();

    // Remaining ALU modes on A=370 (r1), B=4 (r2), B=1 (r7), A=0x80000000 (r5).
    applyStimulus(0, 0, 1, 4'd2, 5'd0, 5'd7, 5'd0, 32'h0);
    pushExp("neg", S_ALU, 32'hFFFFFFFF);
    stepEdge();
    applyStimulus(0, 0, 1, 4'd3, 5'd1, 5'd2, 5'd0, 32'h0);
    pushExp("and", S_ALU, 32'h0);
    stepEdge();
    applyStimulus(0, 0, 1, 4'd4, 5'd1, 5'd2, 5'd0, 32'h0);
    pushExp("or", S_ALU, 32'd374);
    stepEdge();
    applyStimulus(0, 0, 1, 4'd5, 5'd1, 5'd1, 5'd0, 32'h0);
    pushExp("xor_self", S_ALU, 32'h0);
    stepEdge();
    applyStimulus(0, 0, 1, 4'd9, 5'd5, 5'd2, 5'd0, 32'h0);
    pushExp("slt", S_ALU, 32'd1);
    stepEdge();
    applyStimulus(0, 0, 1, 4'd10, 5'd5, 5'd2, 5'd0, 32'h0);
    pushExp("sltu", S_ALU, 32'd0);
    stepEdge();
    applyStimulus(0, 0, 1, 4'd12, 5'd1, 5'd2, 5'd0, 32'h0);
    pushExp("mode12", S_ALU, 32'd0);
    stepEdge();

    // Read-during-write: old value before the edge, new value after.
    applyStimulus(1, 1, 0, 4'd0, 5'd1, 5'd0, 5'd1, 32'h00001234);
    pushExp("rdw_before", S_RD1, 32'd370);
    stepEdge();
    applyStimulus(1, 1, 0, 4'd0, 5'd1, 5'd0, 5'd0, 32'd55);
    pushExp("rdw_after", S_RD1, 32'h00001234);
    stepEdge();
    applyStimulus(0, 1, 0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    pushExp("r0_writable", S_RD1, 32'd55);
    stepEdge();

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
